// File: rtl/ac_sequencer_if.sv
// Control bus between the accumulator-machine sequencer and its datapath.
// The sequencer drives the strobes; the datapath supplies opcode, flags and start.
interface ac_sequencer_if;
  logic       start;
  logic [3:0] opcode;
  logic       flag_c;
  logic       flag_z;
  logic       ir_load;
  logic       pc_inc;
  logic       pc_load;
  logic       ac_load;
  logic [1:0] mux_sel;
  logic       alu_sub;
  logic       mem_rd;
  logic       mem_wr;
  logic       halted;
  logic       illegal;
  logic [2:0] state;
  logic [7:0] retired;

  modport master (
    input  start, opcode, flag_c, flag_z,
    output ir_load, pc_inc, pc_load, ac_load, mux_sel, alu_sub,
           mem_rd, mem_wr, halted, illegal, state, retired
  );

  modport slave (
    output start, opcode, flag_c, flag_z,
    input  ir_load, pc_inc, pc_load, ac_load, mux_sel, alu_sub,
           mem_rd, mem_wr, halted, illegal, state, retired
  );
endinterface

// File: rtl/ac_sequencer.sv
// Control sequencer for a 4-bit-opcode accumulator machine: FETCH/DECODE/MEM/EXEC/HALT.
// Define ILLEGAL_TRAP_EN to make illegal opcodes halt the machine and raise a sticky flag.
module ac_sequencer (
  input  logic          clk,
  input  logic          rst_n,
  ac_sequencer_if.master bus
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_MEM    = 3'd3,
    S_EXEC   = 3'd4,
    S_HALT   = 3'd5
  } state_e;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_STA = 4'h2;
  localparam logic [3:0] OP_ADD = 4'h3;
  localparam logic [3:0] OP_SUB = 4'h4;
  localparam logic [3:0] OP_IN  = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_e     state_q, state_d;
  logic [7:0] retired_q, retired_d;

`ifdef ILLEGAL_TRAP_EN
  logic illegal_q, illegal_d;
`endif

  always_comb begin
    state_d   = state_q;
    retired_d = retired_q;
`ifdef ILLEGAL_TRAP_EN
    illegal_d = illegal_q;
`endif
    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_FETCH;
      S_FETCH:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.opcode)
          OP_NOP: begin
            state_d   = S_FETCH;
            retired_d = retired_q + 8'd1;
          end
          OP_LDA, OP_STA, OP_ADD, OP_SUB: state_d = S_MEM;
          OP_IN, OP_JMP, OP_JC, OP_JZ:    state_d = S_EXEC;
          OP_HLT:                         state_d = S_HALT;
          default: begin
`ifdef ILLEGAL_TRAP_EN
            state_d   = S_HALT;
            illegal_d = 1'b1;
`else
            // Behaves as a NOP but is deliberately not counted as retired.
            state_d   = S_FETCH;
`endif
          end
        endcase
      end
      S_MEM, S_EXEC: begin
        state_d   = S_FETCH;
        retired_d = retired_q + 8'd1;
      end
      S_HALT:  state_d = S_HALT;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      retired_q <= 8'h00;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
`ifdef ILLEGAL_TRAP_EN
      illegal_q <= illegal_d;
`endif
    end
  end

  // Strobes decode from the current state, the held opcode and the live flags.
  logic       ir_load_s, pc_inc_s, pc_load_s, ac_load_s, alu_sub_s, mem_rd_s, mem_wr_s;
  logic [1:0] mux_sel_s;

  always_comb begin
    ir_load_s = 1'b0;
    pc_inc_s  = 1'b0;
    pc_load_s = 1'b0;
    ac_load_s = 1'b0;
    alu_sub_s = 1'b0;
    mem_rd_s  = 1'b0;
    mem_wr_s  = 1'b0;
    mux_sel_s = 2'b00;
    case (state_q)
      S_FETCH: begin
        mem_rd_s  = 1'b1;
        ir_load_s = 1'b1;
        pc_inc_s  = 1'b1;
      end
      S_MEM: begin
        case (bus.opcode)
          OP_LDA: begin
            mem_rd_s  = 1'b1;
            ac_load_s = 1'b1;
            mux_sel_s = 2'b10;
          end
          OP_ADD: begin
            mem_rd_s  = 1'b1;
            ac_load_s = 1'b1;
          end
          OP_SUB: begin
            mem_rd_s  = 1'b1;
            ac_load_s = 1'b1;
            alu_sub_s = 1'b1;
          end
          OP_STA:  mem_wr_s = 1'b1;
          default: ;
        endcase
      end
      S_EXEC: begin
        case (bus.opcode)
          OP_IN: begin
            ac_load_s = 1'b1;
            mux_sel_s = 2'b01;
          end
          OP_JMP:  pc_load_s = 1'b1;
          OP_JC:   pc_load_s = bus.flag_c;
          OP_JZ:   pc_load_s = bus.flag_z;
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  assign bus.ir_load = ir_load_s;
  assign bus.pc_inc  = pc_inc_s;
  assign bus.pc_load = pc_load_s;
  assign bus.ac_load = ac_load_s;
  assign bus.mux_sel = mux_sel_s;
  assign bus.alu_sub = alu_sub_s;
  assign bus.mem_rd  = mem_rd_s;
  assign bus.mem_wr  = mem_wr_s;
  assign bus.halted  = (state_q == S_HALT);
  assign bus.state   = state_q;
  assign bus.retired = retired_q;

`ifdef ILLEGAL_TRAP_EN
  assign bus.illegal = illegal_q;
`else
  assign bus.illegal = 1'b0;
`endif

endmodule

// File: tb/tb_ac_sequencer.sv
// Directed-plus-random bench for ac_sequencer; expectations come from an
// instruction-level model (per-opcode cycle lists and a retired counter).
module tb_ac_sequencer;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  ac_sequencer_if bus ();

  ac_sequencer dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  int   vectors     = 0;
  int   miscompares = 0;
  int   model_ret   = 0;
  logic model_il    = 1'b0;

  // Control word {ir_load,pc_inc,pc_load,ac_load,mux_sel[1:0],alu_sub,mem_rd,mem_wr}
  // for phase 0 (fetch) or phase 2 (the instruction's final MEM/EXEC cycle).
  function automatic logic [8:0] exp_ctrl(input int phase, input logic [3:0] op,
                                          input logic c, input logic z);
    logic [8:0] w;
    w = 9'b0;
    if (phase == 0) w = 9'b1_1_0_0_00_0_1_0;
    else if (phase == 2) begin
      case (op)
        4'h1: w = 9'b0_0_0_1_10_0_1_0;
        4'h2: w = 9'b0_0_0_0_00_0_0_1;
        4'h3: w = 9'b0_0_0_1_00_0_1_0;
        4'h4: w = 9'b0_0_0_1_00_1_1_0;
        4'h5: w = 9'b0_0_0_1_01_0_0_0;
        4'h6: w = 9'b0_0_1_0_00_0_0_0;
        4'h7: w = {2'b00, c, 6'b0};
        4'h8: w = {2'b00, z, 6'b0};
        default: w = 9'b0;
      endcase
    end
    return w;
  endfunction

  task automatic check(input string tag, input logic [2:0] st, input logic hl,
                       input logic il, input logic [8:0] w);
    logic [21:0] obs, expv;
    #1;
    obs  = {bus.state, bus.halted, bus.illegal,
            bus.ir_load, bus.pc_inc, bus.pc_load, bus.ac_load, bus.mux_sel,
            bus.alu_sub, bus.mem_rd, bus.mem_wr, bus.retired};
    expv = {st, hl, il, w, 8'(model_ret)};
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
    vectors++;
    assert (!(bus.pc_inc && bus.pc_load) && !(bus.mem_rd && bus.mem_wr)) else begin
      miscompares++;
      $error("FAIL %s exclusive: observed pc_inc/pc_load=%b%b mem_rd/mem_wr=%b%b expected no pair both high",
             tag, bus.pc_inc, bus.pc_load, bus.mem_rd, bus.mem_wr);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    bus.start  = 1'($urandom);
    bus.flag_c = 1'($urandom);
    bus.flag_z = 1'($urandom);
  endtask

  task automatic reset_and_start();
    rst_n     = 1'b0;
    bus.start = 1'b1;
    tick();
    model_ret = 0;
    model_il  = 1'b0;
    check("reset", 3'd0, 1'b0, 1'b0, 9'b0);
    rst_n     = 1'b1;
    bus.start = 1'b0;
    tick();
    check("idle", 3'd0, 1'b0, 1'b0, 9'b0);
    bus.start = 1'b1;
    tick();
  endtask

  // Called in the FETCH cycle of the instruction; returns in the next FETCH (or HALT).
  task automatic run_instr(input logic [3:0] op, input int fc = -1, input int fz = -1);
    bit is_ill;
    is_ill     = (op >= 4'h9) && (op <= 4'hE);
    bus.opcode = op;
    check($sformatf("op%h fetch", op), 3'd1, 1'b0, model_il, exp_ctrl(0, op, 1'b0, 1'b0));
    tick();
    check($sformatf("op%h decode", op), 3'd2, 1'b0, model_il, 9'b0);
    if (op == 4'h0) begin
      model_ret++;
      tick();
    end else if (op == 4'hF || (TRAP && is_ill)) begin
      if (is_ill) model_il = 1'b1;
      tick();
      check($sformatf("op%h halt", op), 3'd5, 1'b1, model_il, 9'b0);
    end else if (is_ill) begin
      tick();
    end else begin
      tick();
      if (fc >= 0) bus.flag_c = fc[0];
      if (fz >= 0) bus.flag_z = fz[0];
      check($sformatf("op%h last c%0b z%0b", op, bus.flag_c, bus.flag_z),
            (op <= 4'h4) ? 3'd3 : 3'd4, 1'b0, model_il,
            exp_ctrl(2, op, bus.flag_c, bus.flag_z));
      model_ret++;
      tick();
    end
  endtask

  initial begin
    logic [3:0] op;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.opcode = 4'h0;
    bus.flag_c = 1'b0;
    bus.flag_z = 1'b0;
    repeat (2) @(posedge clk);

    // LDA from reset, then conditional jumps with both flag values
    reset_and_start();
    run_instr(4'h1);
    run_instr(4'h7, 0, -1);
    run_instr(4'h7, 1, -1);
    run_instr(4'h8, -1, 0);
    run_instr(4'h8, -1, 1);

    // illegal opcode A
    run_instr(4'hA);
    if (TRAP) reset_and_start();

    // random instruction stream including illegal opcodes
    for (int i = 0; i < 150; i++) begin
      op = 4'($urandom_range(0, 14));
      run_instr(op);
      if (TRAP && op >= 4'h9) reset_and_start();
    end

    // 256 NOPs wrap the retired counter back to zero
    reset_and_start();
    repeat (256) run_instr(4'h0);
    run_instr(4'h3);

    // HLT holds against start pulses until reset
    run_instr(4'hF);
    for (int i = 0; i < 4; i++) begin
      tick();
      bus.start = 1'b1;
      check("halt hold", 3'd5, 1'b1, model_il, 9'b0);
    end
    reset_and_start();
    run_instr(4'h5);

    // reset during the MEM cycle of STA aborts it
    bus.opcode = 4'h2;
    check("sta fetch", 3'd1, 1'b0, model_il, exp_ctrl(0, 4'h2, 1'b0, 1'b0));
    tick();
    check("sta decode", 3'd2, 1'b0, model_il, 9'b0);
    tick();
    check("sta mem", 3'd3, 1'b0, model_il, exp_ctrl(2, 4'h2, 1'b0, 1'b0));
    rst_n = 1'b0;
    tick();
    model_ret = 0;
    model_il  = 1'b0;
    check("sta abort", 3'd0, 1'b0, 1'b0, 9'b0);
    rst_n     = 1'b1;
    bus.start = 1'b1;
    tick();
    run_instr(4'h6);
    run_instr(4'h4);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
